// File: rtl/mdu_scheduler.sv
// Iterative multiply/divide sequencer for the EX stage: owns HI/LO, runs a 32-step
// shift-add / restoring-divide engine and stalls MDU requests that arrive while it is busy.
module mdu_scheduler #(
  parameter int DATA_BUS_WIDTH   = 32,
  parameter int MDU_OP_BUS_WIDTH = 3,
  parameter int CNT_BUS_WIDTH    = 5
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_valid,
  input  logic                        i_flush,
  input  logic [MDU_OP_BUS_WIDTH-1:0] i_op,
  input  logic [DATA_BUS_WIDTH-1:0]   i_rs,
  input  logic [DATA_BUS_WIDTH-1:0]   i_rt,
  output logic                        o_stall,
  output logic                        o_busy,
  output logic [DATA_BUS_WIDTH-1:0]   o_result,
  output logic [DATA_BUS_WIDTH-1:0]   o_hi,
  output logic [DATA_BUS_WIDTH-1:0]   o_lo
);
  localparam int W = DATA_BUS_WIDTH;
  localparam logic [MDU_OP_BUS_WIDTH-1:0] OP_MULT  = MDU_OP_BUS_WIDTH'(0);
  localparam logic [MDU_OP_BUS_WIDTH-1:0] OP_MULTU = MDU_OP_BUS_WIDTH'(1);
  localparam logic [MDU_OP_BUS_WIDTH-1:0] OP_DIV   = MDU_OP_BUS_WIDTH'(2);
  localparam logic [MDU_OP_BUS_WIDTH-1:0] OP_DIVU  = MDU_OP_BUS_WIDTH'(3);
  localparam logic [MDU_OP_BUS_WIDTH-1:0] OP_MFHI  = MDU_OP_BUS_WIDTH'(4);
  localparam logic [MDU_OP_BUS_WIDTH-1:0] OP_MFLO  = MDU_OP_BUS_WIDTH'(5);
  localparam logic [MDU_OP_BUS_WIDTH-1:0] OP_MTHI  = MDU_OP_BUS_WIDTH'(6);
  localparam logic [MDU_OP_BUS_WIDTH-1:0] OP_MTLO  = MDU_OP_BUS_WIDTH'(7);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2} state_t;

  state_t                   state_q, state_d;
  logic [CNT_BUS_WIDTH-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]           p_q, p_d;
  logic [W-1:0]             b_q, b_d;
  logic [W-1:0]             hi_q, hi_d;
  logic [W-1:0]             lo_q, lo_d;
  logic                     is_div_q, is_div_d;
  logic                     neg_q, neg_d;
  logic                     rem_neg_q, rem_neg_d;
  logic                     dz_q, dz_d;

  function automatic logic [W-1:0] abs_w(input logic [W-1:0] x);
    return x[W-1] ? -x : x;
  endfunction

  logic           busy_s, accept_s, signed_op_s, div_op_s;
  logic [W-1:0]   rs_mag_s, rt_mag_s;
  logic [W:0]     mul_sum_s, rem_sh_s, diff_s;
  logic [2*W-1:0] mul_next_s, div_next_s, prod_fix_s;
  logic [W-1:0]   quo_fix_s, rem_fix_s;

  assign busy_s      = (state_q != S_IDLE);
  assign accept_s    = i_valid & ~i_flush & ~busy_s;
  assign signed_op_s = (i_op == OP_MULT) | (i_op == OP_DIV);
  assign div_op_s    = (i_op == OP_DIV) | (i_op == OP_DIVU);
  assign rs_mag_s    = signed_op_s ? abs_w(i_rs) : i_rs;
  assign rt_mag_s    = signed_op_s ? abs_w(i_rt) : i_rt;

  // Multiply: add multiplicand into the upper half when the multiplier LSB is set, then shift right.
  assign mul_sum_s  = {1'b0, p_q[2*W-1:W]} + (p_q[0] ? {1'b0, b_q} : {(W+1){1'b0}});
  assign mul_next_s = {mul_sum_s, p_q[W-1:1]};

  // Divide: shift left, trial-subtract divisor; the borrow bit decides the quotient bit.
  assign rem_sh_s   = {p_q[2*W-1:W], p_q[W-1]};
  assign diff_s     = rem_sh_s - {1'b0, b_q};
  assign div_next_s = {(diff_s[W] ? rem_sh_s[W-1:0] : diff_s[W-1:0]), p_q[W-2:0], ~diff_s[W]};

  assign prod_fix_s = neg_q ? -p_q : p_q;
  assign quo_fix_s  = neg_q ? -p_q[W-1:0] : p_q[W-1:0];
  assign rem_fix_s  = rem_neg_q ? -p_q[2*W-1:W] : p_q[2*W-1:W];

  // Next-state and datapath update for the sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    p_d       = p_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dz_d      = dz_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          case (i_op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              state_d   = S_RUN;
              cnt_d     = CNT_BUS_WIDTH'(W - 1);
              is_div_d  = div_op_s;
              neg_d     = signed_op_s & (i_rs[W-1] ^ i_rt[W-1]);
              rem_neg_d = signed_op_s & i_rs[W-1];
              dz_d      = div_op_s & (i_rt == {W{1'b0}});
              // Divide by zero loads raw rs so the remainder ends up as rs untouched.
              if (div_op_s) begin
                b_d = rt_mag_s;
                p_d = {{W{1'b0}}, ((i_rt == {W{1'b0}}) ? i_rs : rs_mag_s)};
              end else begin
                b_d = rs_mag_s;
                p_d = {{W{1'b0}}, rt_mag_s};
              end
            end
            OP_MTHI: hi_d = i_rs;
            OP_MTLO: lo_d = i_rs;
            default: state_d = S_IDLE;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (i_flush) begin
          state_d = S_IDLE;
        end else begin
          p_d = is_div_q ? div_next_s : mul_next_s;
          if (cnt_q == {CNT_BUS_WIDTH{1'b0}}) begin
            state_d = S_FIX;
          end else begin
            cnt_d = cnt_q - CNT_BUS_WIDTH'(1);
          end
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (i_flush) begin
          hi_d = hi_q;
        end else if (!is_div_q) begin
          hi_d = prod_fix_s[2*W-1:W];
          lo_d = prod_fix_s[W-1:0];
        end else if (dz_q) begin
          hi_d = p_q[2*W-1:W];
          lo_d = {W{1'b1}};
        end else begin
          hi_d = rem_fix_s;
          lo_d = quo_fix_s;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CNT_BUS_WIDTH{1'b0}};
      p_q       <= {(2*W){1'b0}};
      b_q       <= {W{1'b0}};
      hi_q      <= {W{1'b0}};
      lo_q      <= {W{1'b0}};
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      p_q       <= p_d;
      b_q       <= b_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dz_q      <= dz_d;
    end
  end

  // Read-port mux for MFHI/MFLO; zero unless a read is served this cycle.
  always_comb begin
    o_result = {W{1'b0}};
    if (i_valid && !busy_s) begin
      if (i_op == OP_MFHI) begin
        o_result = hi_q;
      end else if (i_op == OP_MFLO) begin
        o_result = lo_q;
      end else begin
        o_result = {W{1'b0}};
      end
    end else begin
      o_result = {W{1'b0}};
    end
  end

  assign o_stall = i_valid & busy_s & ~i_flush;
  assign o_busy  = busy_s;
  assign o_hi    = hi_q;
  assign o_lo    = lo_q;
endmodule

// File: tb/tb_mdu_scheduler.sv
// Self-checking bench for mdu_scheduler: directed and random MDU ops against a
// plain-arithmetic reference model of HI/LO.
module tb_mdu_scheduler;
  logic        clk = 1'b0;
  logic        reset, valid, flush;
  logic [2:0]  op;
  logic [31:0] rs, rt;
  logic        stall, busy;
  logic [31:0] result, hi, lo;
  logic [31:0] m_hi, m_lo;
  int          passed = 0;
  int          total  = 0;

  mdu_scheduler dut (
    .i_clk(clk), .i_reset(reset), .i_valid(valid), .i_flush(flush), .i_op(op),
    .i_rs(rs), .i_rt(rt), .o_stall(stall), .o_busy(busy), .o_result(result),
    .o_hi(hi), .o_lo(lo)
  );

  always #5 clk = ~clk;

  // Reference model: architectural HI/LO after one op, from plain arithmetic.
  function automatic void model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd2: if (b == 32'd0) begin m_hi = a; m_lo = 32'hFFFF_FFFF; end
            else begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
      3'd3: if (b == 32'd0) begin m_hi = a; m_lo = 32'hFFFF_FFFF; end
            else begin m_lo = a / b; m_hi = a % b; end
      3'd6: m_hi = a;
      3'd7: m_lo = a;
      default: ;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op and count the cycles o_busy stays high afterwards (bounded).
  task automatic issue_wait(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                            output int cyc);
    valid = 1'b1; op = o; rs = a; rt = b;
    tick();
    valid = 1'b0;
    cyc = 0;
    while (busy && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    int n;
    valid = 1'b0; flush = 1'b0; op = 3'd0; rs = 32'd0; rt = 32'd0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else passed++;
    total++; if (hi !== 32'd0 || lo !== 32'd0) $display("FAIL reset_hilo got=%h/%h want=0/0", hi, lo); else passed++;
    issue_wait(3'd6, 32'h0000_0011, 32'd0, n);
    valid = 1'b1; op = 3'd0; rs = 32'd9; rt = 32'd9;
    tick();
    op = 3'd4;
    repeat (5) tick();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL reset_midrun_busy got=%b want=0", busy); else passed++;
    total++; if (hi !== 32'd0 || lo !== 32'd0) $display("FAIL reset_midrun_hilo got=%h/%h want=0/0", hi, lo); else passed++;
    total++; if (stall !== 1'b0) $display("FAIL reset_stall got=%b want=0", stall); else passed++;
    total++; if (result !== 32'd0) $display("FAIL reset_result got=%h want=0", result); else passed++;
    valid = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
  endtask

  task automatic test_directed();
    logic [2:0]  t_op [7] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd2, 3'd2};
    logic [31:0] t_rs [7] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'hFFFF_FFF9};
    logic [31:0] t_rt [7] = '{32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] t_hi [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFF, 32'd100, 32'd0, 32'hFFFF_FFF9};
    logic [31:0] t_lo [7] = '{32'hFFFF_FFF1, 32'd1, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    int n;
    for (int i = 0; i < 7; i++) begin
      issue_wait(t_op[i], t_rs[i], t_rt[i], n);
      total++; if (n !== 33) $display("FAIL dir%0d_latency got=%0d want=33", i, n); else passed++;
      total++; if (hi !== t_hi[i]) $display("FAIL dir%0d_hi got=%h want=%h", i, hi, t_hi[i]); else passed++;
      total++; if (lo !== t_lo[i]) $display("FAIL dir%0d_lo got=%h want=%h", i, lo, t_lo[i]); else passed++;
    end
    m_hi = hi; m_lo = lo;
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] a, b;
    int n;
    for (int i = 0; i < 24; i++) begin
      o = 3'($urandom_range(0, 3));
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      if ($urandom_range(0, 3) == 0) a = {a[31], 31'($urandom_range(0, 1000))};
      model_op(o, a, b);
      issue_wait(o, a, b, n);
      total++; if (n !== 33) $display("FAIL rnd%0d_latency got=%0d want=33", i, n); else passed++;
      total++;
      if (hi !== m_hi || lo !== m_lo)
        $display("FAIL rnd%0d op=%0d rs=%h rt=%h got=%h/%h want=%h/%h", i, o, a, b, hi, lo, m_hi, m_lo);
      else passed++;
    end
  endtask

  task automatic test_stall_mflo();
    int stalls = 0;
    model_op(3'd0, 32'd1234567, 32'hFFFF_FFA7);
    valid = 1'b1; op = 3'd0; rs = 32'd1234567; rt = 32'hFFFF_FFA7;
    tick();
    op = 3'd5;
    while (stall && stalls < 100) begin
      stalls++;
      tick();
    end
    total++; if (stalls !== 33) $display("FAIL mflo_stall_cycles got=%0d want=33", stalls); else passed++;
    total++; if (result !== m_lo) $display("FAIL mflo_result got=%h want=%h", result, m_lo); else passed++;
    op = 3'd4;
    #1;
    total++; if (result !== m_hi) $display("FAIL mfhi_result got=%h want=%h", result, m_hi); else passed++;
    tick();
    valid = 1'b0;
    #1;
    total++; if (result !== 32'd0) $display("FAIL result_idle got=%h want=0", result); else passed++;
  endtask

  task automatic test_mt();
    int n;
    issue_wait(3'd6, 32'h1234_5678, 32'd0, n);
    total++; if (hi !== 32'h1234_5678) $display("FAIL mthi got=%h want=12345678", hi); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL mthi_busy got=%b want=0", busy); else passed++;
    issue_wait(3'd7, 32'h9ABC_DEF0, 32'd0, n);
    total++; if (lo !== 32'h9ABC_DEF0 || hi !== 32'h1234_5678)
      $display("FAIL mtlo got=%h/%h want=12345678/9abcdef0", hi, lo); else passed++;
    m_hi = 32'h1234_5678; m_lo = 32'h9ABC_DEF0;
  endtask

  task automatic test_back_to_back();
    int n = 0;
    model_op(3'd3, 32'd1000, 32'd7);
    valid = 1'b1; op = 3'd3; rs = 32'd1000; rt = 32'd7;
    tick();
    op = 3'd1; rs = 32'hDEAD_BEEF; rt = 32'h0001_0003;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    total++; if (n !== 33) $display("FAIL b2b_first_latency got=%0d want=33", n); else passed++;
    total++; if (hi !== m_hi || lo !== m_lo) $display("FAIL b2b_divu got=%h/%h want=%h/%h", hi, lo, m_hi, m_lo); else passed++;
    tick();
    valid = 1'b0;
    total++; if (busy !== 1'b1) $display("FAIL b2b_second_accept got=%b want=1", busy); else passed++;
    model_op(3'd1, 32'hDEAD_BEEF, 32'h0001_0003);
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    total++; if (hi !== m_hi || lo !== m_lo) $display("FAIL b2b_multu got=%h/%h want=%h/%h", hi, lo, m_hi, m_lo); else passed++;
  endtask

  task automatic test_flush();
    int n;
    issue_wait(3'd6, 32'hA5A5_A5A5, 32'd0, n);
    issue_wait(3'd7, 32'hA5A5_A5A5, 32'd0, n);
    valid = 1'b1; op = 3'd2; rs = $urandom; rt = 32'd3;
    tick();
    valid = 1'b0;
    repeat (9) tick();
    flush = 1'b1; valid = 1'b1; op = 3'd5;
    #1;
    total++; if (stall !== 1'b0) $display("FAIL flush_stall got=%b want=0", stall); else passed++;
    tick();
    flush = 1'b0; valid = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL flush_busy got=%b want=0", busy); else passed++;
    repeat (40) tick();
    total++; if (hi !== 32'hA5A5_A5A5 || lo !== 32'hA5A5_A5A5)
      $display("FAIL flush_hilo got=%h/%h want=a5a5a5a5/a5a5a5a5", hi, lo); else passed++;
    valid = 1'b1; flush = 1'b1; op = 3'd0; rs = 32'd3; rt = 32'd4;
    tick();
    total++; if (busy !== 1'b0) $display("FAIL flush_noaccept got=%b want=0", busy); else passed++;
    op = 3'd6; rs = 32'd0;
    tick();
    valid = 1'b0; flush = 1'b0;
    total++; if (hi !== 32'hA5A5_A5A5) $display("FAIL flush_nomt got=%h want=a5a5a5a5", hi); else passed++;
  endtask

  initial begin
    reset = 1'b1; valid = 1'b0; flush = 1'b0; op = 3'd0; rs = 32'd0; rt = 32'd0;
    m_hi = 32'd0; m_lo = 32'd0;
    test_reset();
    test_directed();
    test_random();
    test_stall_mflo();
    test_mt();
    test_back_to_back();
    test_flush();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mdu_scheduler.md
Name: mdu_scheduler

Overview:
- Sequencer for the EX-stage iterative multiply/divide unit (MULT, MULTU, DIV, DIVU) and its HI/LO registers.
- Accepts MDU operations decoded alongside the ALU control path and runs a shared shift-add / restoring-divide engine over 32 iterations.
- Owns HI/LO and serves MFHI/MFLO/MTHI/MTLO.
- Stalls the pipeline whenever a new MDU request arrives while the engine is busy.

Parameters:
- DATA_BUS_WIDTH, 32: operand, HI and LO width.
- MDU_OP_BUS_WIDTH, 3: operation code width.
- CNT_BUS_WIDTH, 5: iteration counter width; must equal clog2(DATA_BUS_WIDTH).

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  MDU request present in EX this cycle.
- i_flush  in  1  abort the in-flight operation and drop the current request.
- i_op  in  MDU_OP_BUS_WIDTH  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MFHI 5=MFLO 6=MTHI 7=MTLO.
- i_rs  in  DATA_BUS_WIDTH  operand A (dividend, multiplicand, MT data).
- i_rt  in  DATA_BUS_WIDTH  operand B (divisor, multiplier).
- o_stall  out  1  hold the pipeline this cycle.
- o_busy  out  1  engine running.
- o_result  out  DATA_BUS_WIDTH  MFHI/MFLO read data.
- o_hi  out  DATA_BUS_WIDTH  architectural HI.
- o_lo  out  DATA_BUS_WIDTH  architectural LO.

Behaviour:
- Reset (synchronous, i_reset=1 at an edge):
  - State returns to IDLE; HI=LO=0; counter=0; o_busy=0.
  - Reset overrides flush and any request; an in-flight operation is discarded.
- States: IDLE, RUN, FIX.
  - IDLE -> RUN on i_valid & op<=3 & !i_flush & !o_busy.
    - Latch operand magnitudes: absolute values for signed ops, raw values for unsigned.
    - Latch result-sign flags: quotient/product sign = rs[31]^rt[31]; remainder sign = rs[31].
    - Latch divide-by-zero flag (rt==0); set counter=31.
  - RUN: one iteration per cycle (multiply: shift-add; divide: restoring shift-subtract).
    - Counter decrements each cycle.
    - At counter==0 -> FIX. RUN lasts exactly 32 cycles.
  - FIX: apply sign correction (two's-complement negate where the flag is set), write HI/LO, -> IDLE.
- Latency and busy:
  - o_busy=1 in RUN and FIX, i.e. for 33 cycles after the accepting edge.
  - HI/LO update on the same edge that drops o_busy.
  - Latency is fixed, including divide-by-zero.
- Results:
  - MULT/MULTU: HI = product[63:32], LO = product[31:0].
  - DIV/DIVU: LO = quotient, HI = remainder.
  - Divide by zero (signed and unsigned): LO = all ones, HI = i_rs as latched, with no sign correction.
  - DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0, with no special-casing.
- Stall:
  - o_stall = i_valid & o_busy & !i_flush (combinational).
  - Any MDU op (including MF/MT) issued while busy stalls until the cycle o_busy is low.
  - Non-MDU instructions are never stalled by this block.
- MFHI/MFLO:
  - o_result = HI (op 4) or LO (op 5), combinational, in the same cycle when i_valid & !o_busy.
  - Otherwise o_result = 0.
- MTHI/MTLO: when accepted in IDLE, write i_rs to HI/LO on that edge; engine not started.
- Flush:
  - i_flush=1 in RUN or FIX forces IDLE on the next edge, with HI/LO unchanged and o_busy=0 thereafter.
  - i_flush wins over a simultaneous i_valid: no acceptance, no MT write.
- A request arriving on the edge FIX completes is not accepted (o_busy still 1); it is accepted on the following edge.
- Undefined ops: none; all 8 codes are defined.

Test Plan:
- Reset: assert i_reset 2 cycles mid-RUN -> o_busy=0, HI=LO=0, o_stall=0 next cycle.
- MULT rs=0xFFFFFFFD (-3), rt=5 -> o_busy high 33 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV rs=7, rt=0xFFFFFFFE (-2) -> LO=0xFFFFFFFD, HI=1.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100/0 -> LO=0xFFFFFFFF, HI=100, same 33-cycle latency.
- MFLO issued 1 cycle after MULT accept -> o_stall=1 for 33 cycles.
  - Then o_result = new LO in the first cycle o_busy=0.
  - MTHI 0x12345678 while idle -> o_hi=0x12345678 next cycle.
- i_flush at RUN cycle 10 of DIV with HI=LO=0xA5A5A5A5 -> IDLE next edge, HI/LO still 0xA5A5A5A5.
  - Simultaneous i_valid+i_flush -> no acceptance.
